// File: rtl/store_checker.sv
// store_checker: observes core data-memory stores, logs them, and decides pass/fail in hardware.
// Latency: verdict, count and log push all update on the same edge that samples the store.
// Backpressure: none toward the core; when the log is full, stores are dropped and log_ovf is set.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   memWrite/dataAddr/writeData  store strobe, address and data from the core
//   log_rd                       pop the oldest log entry (ignored while the log is empty)
//   log_valid/log_addr/log_data  first-word-fall-through view of the oldest logged store
//   log_ovf                      sticky flag: a store was dropped because the log was full
//   store_count                  saturating count of accepted stores
//   done/pass/fail               verdict flags, sticky until reset
//   verdict_addr/verdict_data    the store that produced the verdict
// Optional build macro STORE_CHECK_TIMEOUT_EN: forces a fail TIMEOUT cycles after reset if no verdict.
module store_checker #(
  parameter logic [31:0] PASS_ADDR  = 32'd84,
  parameter logic [31:0] PASS_DATA  = 32'd7,
  parameter logic [31:0] ALLOW_ADDR = 32'd80,
  parameter int          LOG_DEPTH  = 8,
  parameter int          CNT_W      = 16,
  parameter int          TIMEOUT    = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memWrite,
  input  logic [31:0]      dataAddr,
  input  logic [31:0]      writeData,
  input  logic             log_rd,
  output logic             log_valid,
  output logic [31:0]      log_addr,
  output logic [31:0]      log_data,
  output logic             log_ovf,
  output logic [CNT_W-1:0] store_count,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [31:0]      verdict_addr,
  output logic [31:0]      verdict_data
);
  localparam int AW = $clog2(LOG_DEPTH);

  typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_decide;
  logic             w_timeout;

  logic [31:0]      r_log_addr [LOG_DEPTH];
  logic [31:0]      r_log_data [LOG_DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_occ;
  logic             r_ovf;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_vaddr;
  logic [31:0]      r_vdata;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  assign w_accept = memWrite && (r_state == ST_RUN);

`ifdef STORE_CHECK_TIMEOUT_EN
  logic [31:0] r_cyc;
  always_ff @(posedge clk) begin
    if (rst)                    r_cyc <= '0;
    else if (r_state == ST_RUN) r_cyc <= r_cyc + 32'd1;
  end
  // r_cyc counts edges since reset; the TIMEOUT-th edge is the one that forces the fail.
  assign w_timeout = (r_state == ST_RUN) && !w_decide && (r_cyc == 32'(TIMEOUT - 1));
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT != 0);
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_decide    = 1'b0;
    if (w_accept) begin
      if (dataAddr == PASS_ADDR) begin
        w_decide    = 1'b1;
        w_state_nxt = (writeData == PASS_DATA) ? ST_PASS : ST_FAIL;
      end else if (dataAddr != ALLOW_ADDR) begin
        w_decide    = 1'b1;
        w_state_nxt = ST_FAIL;
      end
    end
    if (w_timeout) w_state_nxt = ST_FAIL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_vaddr <= '0;
      r_vdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_decide) begin
        r_vaddr <= dataAddr;
        r_vdata <= writeData;
      end else if (w_timeout) begin
        r_vaddr <= '0;
        r_vdata <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                            r_count <= '0;
    else if (w_accept && r_count != '1) r_count <= r_count + 1'b1;
  end

  // A pop frees a slot on the same edge, so a full log can still take a push if it is also popped.
  assign w_full = (r_occ == (AW+1)'(LOG_DEPTH));
  assign w_pop  = log_rd && (r_occ != '0);
  assign w_push = w_accept && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_log_addr[r_wp] <= dataAddr;
      r_log_data[r_wp] <= writeData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_occ <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)      r_occ <= r_occ + 1'b1;
      else if (w_pop && !w_push) r_occ <= r_occ - 1'b1;
      if (w_accept && !w_push)   r_ovf <= 1'b1;
    end
  end

  assign log_valid    = (r_occ != '0);
  assign log_addr     = r_log_addr[r_rp];
  assign log_data     = r_log_data[r_rp];
  assign log_ovf      = r_ovf;
  assign store_count  = r_count;
  assign pass         = (r_state == ST_PASS);
  assign fail         = (r_state == ST_FAIL);
  assign done         = pass | fail;
  assign verdict_addr = r_vaddr;
  assign verdict_data = r_vdata;
endmodule

// File: tb/tb_store_checker.sv
// Randomized bench for store_checker with a queue-based reference model and literal scenario checks.
module tb_store_checker;
  localparam int LD = 8;
  localparam int CW = 4;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          memWrite = 1'b0;
  logic [31:0]   dataAddr = '0;
  logic [31:0]   writeData = '0;
  logic          log_rd = 1'b0;
  logic          log_valid, log_ovf, done, pass, fail;
  logic [31:0]   log_addr, log_data, verdict_addr, verdict_data;
  logic [CW-1:0] store_count;

  int n_checks = 0;
  int n_fail   = 0;

  store_checker #(.LOG_DEPTH(LD), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .memWrite(memWrite), .dataAddr(dataAddr), .writeData(writeData),
    .log_rd(log_rd), .log_valid(log_valid), .log_addr(log_addr), .log_data(log_data),
    .log_ovf(log_ovf), .store_count(store_count), .done(done), .pass(pass), .fail(fail),
    .verdict_addr(verdict_addr), .verdict_data(verdict_data));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: verdict 0=running 1=pass 2=fail, log as a queue of {addr,data}.
  bit          m_live = 0;
  int          m_v;
  logic [63:0] m_q[$];
  bit          m_ovf;
  int          m_cnt;
  logic [31:0] m_va, m_vd;
  int          m_cyc;

  always @(posedge clk) begin
    bit pop_ok, acc, dec;
    if (rst) begin
      m_live = 1; m_v = 0; m_q.delete(); m_ovf = 0; m_cnt = 0; m_va = 0; m_vd = 0; m_cyc = 0;
    end else if (m_live) begin
      pop_ok = log_rd && (m_q.size() > 0);
      acc    = memWrite && (m_v == 0);
      dec    = 0;
      if (pop_ok) m_q.delete(0);
      if (acc) begin
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        if (m_q.size() < LD) m_q.push_back({dataAddr, writeData});
        else m_ovf = 1;
        if (dataAddr == 32'd84) begin
          dec = 1; m_v = (writeData == 32'd7) ? 1 : 2;
        end else if (dataAddr != 32'd80) begin
          dec = 1; m_v = 2;
        end
        if (dec) begin m_va = dataAddr; m_vd = writeData; end
      end
`ifdef STORE_CHECK_TIMEOUT_EN
      if (m_v == 0 || dec) begin
        if (!dec && m_cyc == TO - 1) begin m_v = 2; m_va = 0; m_vd = 0; end
        else m_cyc++;
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("log_valid", 64'(log_valid), 64'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        check("log_addr", 64'(log_addr), 64'(m_q[0][63:32]));
        check("log_data", 64'(log_data), 64'(m_q[0][31:0]));
      end
      check("log_ovf", 64'(log_ovf), 64'(m_ovf));
      check("store_count", 64'(store_count), 64'(m_cnt));
      check("done", 64'(done), 64'(m_v != 0));
      check("pass", 64'(pass), 64'(m_v == 1));
      check("fail", 64'(fail), 64'(m_v == 2));
      check("verdict_addr", 64'(verdict_addr), 64'(m_va));
      check("verdict_data", 64'(verdict_data), 64'(m_vd));
    end
  end

  // Called at a falling edge: drive inputs for the next rising edge, return at the following falling edge.
  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rd);
    memWrite = we; dataAddr = a; writeData = d; log_rd = rd;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 32'd0, 32'd0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic expect_pop(input string nm, input logic [31:0] a, input logic [31:0] d);
    check({nm, "_valid"}, 64'(log_valid), 64'd1);
    check({nm, "_addr"}, 64'(log_addr), 64'(a));
    check({nm, "_data"}, 64'(log_data), 64'(d));
    cyc(1'b0, 32'd0, 32'd0, 1'b1);
  endtask

  initial begin
    int len, r;
    logic [31:0] a, d;
    @(negedge clk);

    // Reset state.
    do_reset();
    check("rst_done", 64'(done), 64'd0);
    check("rst_count", 64'(store_count), 64'd0);
    check("rst_valid", 64'(log_valid), 64'd0);

    // Two allowed stores then the pass store.
    cyc(1'b1, 32'd80, 32'd5, 1'b0);
    cyc(1'b1, 32'd80, 32'd9, 1'b0);
    check("pre_pass_done", 64'(done), 64'd0);
    cyc(1'b1, 32'd84, 32'd7, 1'b0);
    check("p_done", 64'(done), 64'd1);
    check("p_pass", 64'(pass), 64'd1);
    check("p_fail", 64'(fail), 64'd0);
    check("p_count", 64'(store_count), 64'd3);
    check("p_vaddr", 64'(verdict_addr), 64'd84);
    check("p_vdata", 64'(verdict_data), 64'd7);
    expect_pop("p_pop0", 32'd80, 32'd5);
    expect_pop("p_pop1", 32'd80, 32'd9);
    expect_pop("p_pop2", 32'd84, 32'd7);
    check("p_empty", 64'(log_valid), 64'd0);

    // Wrong data at the pass address, then a store that must be ignored.
    do_reset();
    cyc(1'b1, 32'd84, 32'd6, 1'b0);
    check("bd_fail", 64'(fail), 64'd1);
    check("bd_vdata", 64'(verdict_data), 64'd6);
    cyc(1'b1, 32'd84, 32'd7, 1'b0);
    check("bd_pass", 64'(pass), 64'd0);
    check("bd_count", 64'(store_count), 64'd1);

    // Disallowed address.
    do_reset();
    cyc(1'b1, 32'd88, 32'd7, 1'b0);
    check("ba_fail", 64'(fail), 64'd1);
    check("ba_vaddr", 64'(verdict_addr), 64'd88);

    // Overflow: nine stores into an eight-entry log.
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1'b1, 32'd80, 32'(i), 1'b0);
    check("of_ovf", 64'(log_ovf), 64'd1);
    check("of_count", 64'(store_count), 64'd9);
    check("of_done", 64'(done), 64'd0);
    for (int i = 0; i < 8; i++) expect_pop("of_pop", 32'd80, 32'(i));
    check("of_empty", 64'(log_valid), 64'd0);

    // Full log with a simultaneous pop on the ninth store: no overflow.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'd80, 32'(i), 1'b0);
    cyc(1'b1, 32'd80, 32'd8, 1'b1);
    check("fp_ovf", 64'(log_ovf), 64'd0);
    for (int i = 1; i < 9; i++) expect_pop("fp_pop", 32'd80, 32'(i));

    // Empty log with push and pop together: only the push happens.
    do_reset();
    cyc(1'b1, 32'd80, 32'd3, 1'b1);
    expect_pop("ep_pop", 32'd80, 32'd3);

    // Reset after a pass clears everything; a new run passes again.
    do_reset();
    cyc(1'b1, 32'd84, 32'd7, 1'b0);
    do_reset();
    check("rr_done", 64'(done), 64'd0);
    check("rr_vaddr", 64'(verdict_addr), 64'd0);
    check("rr_count", 64'(store_count), 64'd0);
    check("rr_valid", 64'(log_valid), 64'd0);
    cyc(1'b1, 32'd84, 32'd7, 1'b0);
    check("rr_pass", 64'(pass), 64'd1);

`ifdef STORE_CHECK_TIMEOUT_EN
    do_reset();
    for (int i = 0; i < TO - 1; i++) cyc(1'b0, 32'd0, 32'd0, 1'b0);
    check("to_early", 64'(fail), 64'd0);
    cyc(1'b0, 32'd0, 32'd0, 1'b0);
    check("to_fail", 64'(fail), 64'd1);
    check("to_vaddr", 64'(verdict_addr), 64'd0);
    do_reset();
    for (int i = 0; i < TO - 1; i++) cyc(1'b0, 32'd0, 32'd0, 1'b0);
    cyc(1'b1, 32'd84, 32'd7, 1'b0);
    check("to_pass", 64'(pass), 64'd1);
    check("to_nofail", 64'(fail), 64'd0);
`endif

    // Randomized runs, each starting with a reset from whatever state the last run left.
    for (int run = 0; run < 40; run++) begin
      do_reset();
      len = $urandom_range(10, 60);
      for (int c = 0; c < len; c++) begin
        r = $urandom_range(0, 15);
        if (r < 11)      a = 32'd80;
        else if (r < 14) a = 32'd84;
        else             a = $urandom_range(0, 200);
        d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'd7;
        cyc(($urandom_range(0, 3) != 0), a, d, ($urandom_range(0, 2) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/store_checker.md
Name: store_checker

Overview:
- Responder/observer on the processor's data-memory write interface (`memWrite`, `dataAddr`, `writeData`). It consumes every store the core issues.
- Decides pass/fail in hardware: a store of PASS_DATA to PASS_ADDR is a pass; any store to an address other than ALLOW_ADDR is a fail.
- Keeps a drainable log of accepted stores.
- Sits beside `top` in the simulation and FPGA harness, so verdicts need no bench-side `$display` logic.

Parameters:
- PASS_ADDR, 32'd84: store address that ends the run.
- PASS_DATA, 32'd7: data required at PASS_ADDR for a pass.
- ALLOW_ADDR, 32'd80: only other address a store may target without failing.
- LOG_DEPTH, 8: store-log FIFO entries; power of two, ≥2.
- CNT_W, 16: width of `store_count`.
- TIMEOUT, 1000: cycles after reset release before a forced fail (optional feature only).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- memWrite  in  1  store strobe from core, one store per cycle when high
- dataAddr  in  32  store byte address
- writeData  in  32  store data
- log_rd  in  1  pop request for store log
- log_valid  out  1  log non-empty; `log_addr`/`log_data` valid
- log_addr  out  32  address of oldest logged store
- log_data  out  32  data of oldest logged store
- log_ovf  out  1  sticky: a store was dropped because the log was full
- store_count  out  CNT_W  number of stores accepted in RUN, saturating
- done  out  1  verdict reached
- pass  out  1  verdict is pass
- fail  out  1  verdict is fail
- verdict_addr  out  32  address of the store that produced the verdict
- verdict_data  out  32  data of that store

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=RUN; log emptied.
  - `log_valid`, `log_ovf`, `store_count`, `done`, `pass`, `fail`, `verdict_addr`, `verdict_data` all 0.
  - Reset mid-run or post-verdict clears everything on that same edge.
- States are RUN, PASS, FAIL. PASS and FAIL are sticky until rst.
- Store is accepted when memWrite=1 in RUN at a rising edge. Classification of an accepted store:
  - dataAddr==PASS_ADDR and writeData==PASS_DATA → PASS.
  - dataAddr==PASS_ADDR and writeData!=PASS_DATA → FAIL.
  - dataAddr==ALLOW_ADDR → remain RUN.
  - Any other address → FAIL.
- Verdict timing:
  - `done`, `pass`, `fail`, `verdict_addr`, `verdict_data` update on the same edge as the deciding store, i.e. visible 1 cycle after the store is presented.
  - `done = pass | fail`; `pass` and `fail` are never both 1.
- In PASS or FAIL:
  - memWrite is ignored: no count, no log push, no verdict change.
- `store_count`:
  - +1 per accepted store, including the deciding one.
  - Holds at 2^CNT_W−1.
- Store log: FIFO of {addr, data}, LOG_DEPTH entries, first-word fall-through.
  - Push on each accepted store.
  - Pop when log_rd=1 and log_valid=1; log_rd with an empty log is ignored.
  - Full with push and no pop: store dropped, `log_ovf`←1 (sticky), verdict logic still evaluates the store.
  - Full with push and pop on the same edge: both occur, occupancy unchanged, no overflow.
  - Empty with push and pop on the same edge: pop ignored, push occurs.
  - Pointers wrap modulo LOG_DEPTH; occupancy counter is log2(LOG_DEPTH)+1 bits.
  - Pops remain allowed after the verdict.
- `log_addr`/`log_data` are undefined-but-stable (hold last value) when log_valid=0.

Optional Feature:
- Macro: STORE_CHECK_TIMEOUT_EN
- Defined:
  - A cycle counter starts at 0 on reset release and increments each cycle in RUN.
  - When it reaches TIMEOUT with no verdict, state→FAIL with `verdict_addr`=0 and `verdict_data`=0 on that edge.
  - A deciding store on the same edge takes priority over the timeout.
- Not defined: no counter logic; RUN may persist indefinitely.

Test Plan:
- Reset, then store (80,5), (80,9), (84,7) on consecutive cycles → one cycle after (84,7): done=1, pass=1, fail=0, store_count=3, verdict_addr=84, verdict_data=7; log pops return (80,5),(80,9),(84,7).
- Store (84,6) → fail=1, verdict_data=6; a following store (84,7) is ignored, pass stays 0, store_count=1.
- Store (88,7) → fail=1, verdict_addr=88.
- LOG_DEPTH=8, 9 stores to 80 without pops → log_ovf=1, 8 entries drained, store_count=9, still RUN. Repeat with log_rd=1 on the 9th store → log_ovf=0.
- Pass reached, then rst=1 for one cycle → all outputs 0, log empty; new run (84,7) passes again.
- With STORE_CHECK_TIMEOUT_EN and TIMEOUT=20, no stores → fail=1 exactly 20 cycles after rst deasserts, verdict_addr=0. Store (84,7) on the timeout cycle → pass=1 instead.
